// File: rtl/sd_blk_pkg.sv
// rtl/sd_blk_pkg.sv - shared types and widths for the SD block-channel arbiter
package sd_blk_pkg;

    localparam int SD_LBA_W  = 32;
    localparam int SD_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        DONE,
        ABORT
    } arb_state_t;

    // Round-robin pointer successor with wrap at nreq-1.
    function automatic logic [1:0] rr_next(input logic [1:0] id, input int nreq);
        if (int'(id) + 1 >= nreq) begin
            return 2'd0;
        end
        return id + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority encoder: first pending requester at or after rr_ptr
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      rr_ptr,
    output logic [1:0]      winner,
    output logic            valid
);

    int idx;

    // Scan from the farthest offset down so the nearest pending index overrides.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (pending[idx[1:0]]) begin
                winner = idx[1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_blk_arbiter.sv
// rtl/sd_blk_arbiter.sv - shares one SD block channel among NREQ requesters, round-robin per block
module sd_blk_arbiter
    import sd_blk_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int TMO_W = 20
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NREQ-1:0]             req_rd,
    input  logic [NREQ-1:0]             req_wr,
    input  logic [NREQ*SD_LBA_W-1:0]    req_lba,
    input  logic [NREQ*SD_DATA_W-1:0]   req_buff_din,
    output logic [NREQ-1:0]             req_ack,
    output logic [NREQ-1:0]             req_buff_wr,
    output logic [NREQ-1:0]             req_err,
    output logic [SD_LBA_W-1:0]         sd_lba,
    output logic                        sd_rd,
    output logic                        sd_wr,
    input  logic                        sd_ack,
    input  logic                        sd_buff_wr,
    output logic [SD_DATA_W-1:0]        sd_buff_din,
    output logic [1:0]                  grant_id,
    output logic                        busy
);

    arb_state_t           state;
    logic [1:0]           rr_ptr;
    logic                 op_rd;
    logic [TMO_W-1:0]     tmo;
    logic [NREQ-1:0]      pending;
    logic [1:0]           pick_id;
    logic                 pick_valid;
    logic [SD_LBA_W-1:0]  lba_arr [NREQ];
    logic [SD_DATA_W-1:0] din_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign lba_arr[i] = req_lba[SD_LBA_W*i +: SD_LBA_W];
        assign din_arr[i] = req_buff_din[SD_DATA_W*i +: SD_DATA_W];
    end

    assign pending = req_rd | req_wr;
    assign busy    = (state != IDLE);

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .pending(pending),
        .rr_ptr (rr_ptr),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            sd_lba   <= '0;
            req_err  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            op_rd    <= 1'b0;
            tmo      <= '0;
        end else begin
            req_err <= '0;
            case (state)
                IDLE: begin
                    // A leftover ack from an interrupted transfer blocks new grants.
                    if (pick_valid && !sd_ack) begin
                        grant_id <= pick_id;
                        sd_lba   <= lba_arr[pick_id];
                        op_rd    <= req_rd[pick_id];
                        tmo      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (&tmo) begin
                        sd_rd             <= 1'b0;
                        sd_wr             <= 1'b0;
                        req_err[grant_id] <= 1'b1;
                        state             <= ABORT;
                    end else begin
                        sd_rd <= op_rd;
                        sd_wr <= !op_rd;
                        tmo   <= tmo + 1'b1;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= rr_next(grant_id, NREQ);
                    state  <= IDLE;
                end
                ABORT: begin
                    rr_ptr <= rr_next(grant_id, NREQ);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        sd_buff_din = '0;
        if (state == XFER) begin
            req_ack[grant_id]     = sd_ack;
            req_buff_wr[grant_id] = sd_buff_wr;
            sd_buff_din           = din_arr[grant_id];
        end
    end

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// tb/tb_sd_blk_arbiter.sv - self-checking bench for sd_blk_arbiter
module tb_sd_blk_arbiter;
    import sd_blk_pkg::*;

    localparam int NREQ    = 3;
    localparam int TMO_W   = 4;
    localparam int TMO_LIM = (1 << TMO_W) - 1;
    localparam int ACK_DLY = 10;
    localparam int NSTB    = 256;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [NREQ-1:0]   req_rd = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [NREQ*32-1:0] req_lba = '0;
    logic [NREQ*8-1:0] req_buff_din = '0;
    logic [NREQ-1:0]   req_ack, req_buff_wr, req_err;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr;
    logic              sd_ack = 1'b0;
    logic              sd_buff_wr = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [1:0]        grant_id;
    logic              busy;

    always #5 CLK = ~CLK;

    sd_blk_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_buff_din(req_buff_din),
        .req_ack(req_ack), .req_buff_wr(req_buff_wr), .req_err(req_err),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .grant_id(grant_id), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Transaction-level reference: who holds the channel and which phase of its block it is in.
    bit          m_cur, m_acked, m_closing, m_tmo;
    int          m_treq, m_ptr, m_last, m_id, m_j;
    logic        m_rd;
    logic [31:0] m_lba;
    int          m_glog[$];

    always @(posedge CLK) begin
        if (RESET) begin
            m_cur = 0; m_acked = 0; m_closing = 0; m_tmo = 0;
            m_treq = 0; m_ptr = 0; m_last = 0; m_id = 0; m_rd = 1'b0; m_lba = '0;
        end else if (!m_cur) begin
            if (!sd_ack) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_j = (m_ptr + k) % NREQ;
                    if (!m_cur && (req_rd[m_j] || req_wr[m_j])) begin
                        m_cur = 1; m_acked = 0; m_closing = 0; m_tmo = 0; m_treq = 0;
                        m_id = m_j; m_last = m_j; m_rd = req_rd[m_j];
                        m_lba = req_lba[32*m_j +: 32];
                        m_glog.push_back(m_j);
                    end
                end
            end
        end else if (m_closing) begin
            m_cur = 0; m_closing = 0; m_ptr = (m_id + 1) % NREQ;
        end else if (m_acked) begin
            if (!sd_ack) m_closing = 1;
        end else if (sd_ack) begin
            m_acked = 1;
        end else if (m_treq == TMO_LIM) begin
            m_closing = 1; m_tmo = 1;
        end else begin
            m_treq++;
        end
    end

    logic [NREQ-1:0] e_ack, e_bwr, e_err;
    logic [7:0]      e_din;
    logic            e_rd, e_wr, in_xfer;

    always @(negedge CLK) begin
        if (chk_on) begin
            e_ack = '0; e_bwr = '0; e_err = '0; e_din = '0;
            in_xfer = m_cur && m_acked && !m_closing;
            if (in_xfer) begin
                e_ack[m_id] = sd_ack;
                e_bwr[m_id] = sd_buff_wr;
                e_din = req_buff_din[8*m_id +: 8];
            end
            if (m_cur && m_closing && m_tmo) e_err[m_id] = 1'b1;
            e_rd = m_cur && !m_acked && !m_closing && (m_treq >= 1) && m_rd;
            e_wr = m_cur && !m_acked && !m_closing && (m_treq >= 1) && !m_rd;
            chk("busy", busy, m_cur);
            chk("grant_id", grant_id, m_last);
            chk("sd_lba", sd_lba, m_lba);
            chk("sd_rd", sd_rd, e_rd);
            chk("sd_wr", sd_wr, e_wr);
            chk("req_ack", req_ack, e_ack);
            chk("req_buff_wr", req_buff_wr, e_bwr);
            chk("req_err", req_err, e_err);
            chk("sd_buff_din", sd_buff_din, e_din);
        end
    end

    // hps_io side model and requester agents, all advanced from step().
    int            hps_st = 0, hps_cnt = 0, hps_nstb = 0;
    bit            hps_mute = 1'b0;
    logic [7:0]    cap [NSTB];
    int            nbw [NREQ];
    int            nack[NREQ];
    int            nerr[NREQ];
    int            nrd_hi = 0;
    logic [NREQ-1:0] pack = '0;
    logic          p_rd = 1'b0, p_wr = 1'b0;
    logic [32:0]   oplog[$];
    logic [7:0]    ramp;

    task automatic step();
        @(posedge CLK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_buff_wr[i]) nbw[i]++;
            if (req_ack[i]) nack[i]++;
            if (req_err[i]) nerr[i]++;
            if ((req_ack[i] && !pack[i]) || req_err[i]) begin
                if (req_rd[i]) req_rd[i] = 1'b0;
                else req_wr[i] = 1'b0;
            end
        end
        pack = req_ack;
        if (sd_rd) nrd_hi++;
        if (sd_rd && !p_rd) oplog.push_back({1'b0, sd_lba});
        if (sd_wr && !p_wr) oplog.push_back({1'b1, sd_lba});
        p_rd = sd_rd;
        p_wr = sd_wr;
        case (hps_st)
            0: if (!hps_mute && (sd_rd || sd_wr)) begin hps_st = 1; hps_cnt = 0; end
            1: begin
                hps_cnt++;
                if (hps_cnt >= ACK_DLY) begin sd_ack = 1'b1; hps_st = 2; hps_nstb = 0; end
            end
            2: begin
                if (sd_buff_wr) begin
                    cap[hps_nstb] = sd_buff_din;
                    sd_buff_wr = 1'b0;
                    hps_nstb++;
                    if (hps_nstb == NSTB) hps_st = 3;
                end else begin
                    sd_buff_wr = 1'b1;
                end
            end
            default: begin sd_ack = 1'b0; hps_st = 0; end
        endcase
        ramp = (hps_st == 2) ? 8'(hps_nstb) : 8'hA5;
        req_buff_din = {ramp, 8'h55, 8'h55};
    endtask

    task automatic clear_logs();
        m_glog.delete();
        oplog.delete();
        for (int i = 0; i < NREQ; i++) begin nbw[i] = 0; nack[i] = 0; nerr[i] = 0; end
        for (int i = 0; i < NSTB; i++) cap[i] = 8'h00;
        nrd_hi = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((busy || (req_rd | req_wr) != '0 || hps_st != 0) && n < max) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= max) begin
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles", name, n);
        end
    endtask

    function automatic int glog_code();
        int c;
        c = 0;
        foreach (m_glog[k]) c = c * 10 + m_glog[k] + 1;
        return c;
    endfunction

    initial begin
        int n, nbad_ramp, nstale;
        for (int i = 0; i < NREQ; i++) begin nbw[i] = 0; nack[i] = 0; nerr[i] = 0; end
        RESET = 1'b1;
        step();
        chk_on = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sd_rd", {sd_rd, sd_wr}, 2'b00);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_sd_lba", sd_lba, 32'h0);
        chk("rst_req_err", req_err, 3'b000);
        RESET = 1'b0;
        clear_logs();

        // Single read on requester 1.
        req_lba[32*1 +: 32] = 32'h0000_0123;
        req_rd[1] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!sd_rd && n < 20);
        chk("t1_rd_latency", n, 2);
        chk("t1_sd_lba", sd_lba, 32'h123);
        wait_idle("t1_idle", 2000);
        chk("t1_bwr_granted", nbw[1], NSTB);
        chk("t1_bwr_others", nbw[0] + nbw[2], 0);
        chk("t1_ack_others", nack[0] + nack[2], 0);
        chk("t1_grants", glog_code(), 2);

        // Contention: 0,1,2 together, 0 again during the second transfer.
        do_reset();
        req_lba = {32'h12, 32'h11, 32'h10};
        req_rd[0] = 1'b1; req_rd[1] = 1'b1; req_wr[2] = 1'b1;
        n = 0;
        while (!req_ack[1] && n < 3000) begin step(); n++; end
        chk("t2_second_ack_seen", n < 3000, 1'b1);
        req_lba[32*0 +: 32] = 32'h20;
        req_rd[0] = 1'b1;
        wait_idle("t2_idle", 5000);
        chk("t2_grants", glog_code(), 1231);
        chk("t2_op_count", oplog.size(), 4);
        chk("t2_op_last", oplog[3], {1'b0, 32'h20});
        chk("t2_op_third", oplog[2], {1'b1, 32'h12});

        // Write data path from requester 2.
        do_reset();
        req_lba[32*2 +: 32] = 32'h3000;
        req_wr[2] = 1'b1;
        wait_idle("t3_idle", 2000);
        nbad_ramp = 0;
        for (int i = 0; i < NSTB; i++) if (cap[i] !== 8'(i)) nbad_ramp++;
        chk("t3_ramp_bad_bytes", nbad_ramp, 0);
        chk("t3_ops", oplog.size(), 1);
        chk("t3_op0", oplog[0], {1'b1, 32'h3000});
        step();
        chk("t3_din_after", sd_buff_din, 8'h00);

        // Ack-start timeout on requester 0, then requester 1 is served.
        do_reset();
        hps_mute = 1'b1;
        req_lba[32*0 +: 32] = 32'h40;
        req_lba[32*1 +: 32] = 32'h41;
        req_rd[0] = 1'b1; req_rd[1] = 1'b1;
        n = 0;
        while (nerr[0] == 0 && n < 100) begin step(); n++; end
        chk("t4_rd_high_cycles", nrd_hi, TMO_LIM);
        hps_mute = 1'b0;
        wait_idle("t4_idle", 2000);
        chk("t4_err0_pulses", nerr[0], 1);
        chk("t4_err1_pulses", nerr[1], 0);
        chk("t4_grants", glog_code(), 12);

        // Reset in the middle of a transfer; stale ack must hold off the next grant.
        do_reset();
        req_lba[32*0 +: 32] = 32'h50;
        req_lba[32*1 +: 32] = 32'h51;
        req_rd[0] = 1'b1;
        n = 0;
        while (nbw[0] < 20 && n < 500) begin step(); n++; end
        RESET = 1'b1;
        req_rd[1] = 1'b1;
        step();
        RESET = 1'b0;
        chk("t5_rst_rdwr", {sd_rd, sd_wr}, 2'b00);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_grant_id", grant_id, 2'd0);
        chk("t5_ack_still_high", sd_ack, 1'b1);
        nstale = 0;
        n = 0;
        while (sd_ack && n < 1000) begin step(); if (busy) nstale++; n++; end
        chk("t5_stale_busy", nstale, 0);
        wait_idle("t5_idle", 2000);
        chk("t5_grants", glog_code(), 12);
        chk("t5_bwr1", nbw[1], NSTB);

        // Read and write together on requester 0.
        do_reset();
        req_lba[32*0 +: 32] = 32'h777;
        req_rd[0] = 1'b1; req_wr[0] = 1'b1;
        wait_idle("t6_idle", 3000);
        chk("t6_grants", glog_code(), 11);
        chk("t6_op_count", oplog.size(), 2);
        chk("t6_op0", oplog[0], {1'b0, 32'h777});
        chk("t6_op1", oplog[1], {1'b1, 32'h777});

        step();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
